// File: rtl/key_repeat_filter.sv
// rtl/key_repeat_filter.sv - multi-key synchroniser, debounce and hold-to-repeat pulse generator
//
// Purpose:
//   Conditions N_KEYS active-low push-buttons for the block-movement logic.
//   Each key has its own path: a 2-FF synchroniser, a debounce FSM and an
//   auto-repeat generator. The keys share no counters and are not arbitrated.
//
// Ports:
//   clk        in   1       system clock
//   rst_n      in   1       synchronous active-low reset
//   key_in     in   N_KEYS  raw asynchronous buttons, 0 = pressed
//   rpt_en     in   N_KEYS  per-key auto-repeat enable, 1 = enabled
//   nege_flag  out  N_KEYS  one-cycle pulse when a debounced press is accepted
//   pose_flag  out  N_KEYS  one-cycle pulse when a debounced release is accepted
//   rpt_flag   out  N_KEYS  one-cycle auto-repeat pulse while the key is held
//   move_flag  out  N_KEYS  nege_flag | rpt_flag, registered
//   key_state  out  N_KEYS  debounced level, 0 = pressed
module key_repeat_filter #(
  parameter int N_KEYS        = 4,
  parameter int CNT_DEBOUNCE  = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] rpt_en,
  output logic [N_KEYS-1:0] nege_flag,
  output logic [N_KEYS-1:0] pose_flag,
  output logic [N_KEYS-1:0] rpt_flag,
  output logic [N_KEYS-1:0] move_flag,
  output logic [N_KEYS-1:0] key_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILTER_DN = 2'd1,
    DOWN      = 2'd2,
    FILTER_UP = 2'd3
  } state_t;

  // Terminal counter values: a count that reaches these has lasted exactly
  // CNT_DEBOUNCE / REPEAT_DELAY / REPEAT_PERIOD cycles.
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(CNT_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic             sync1;
    logic             sync2;
    state_t           state;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rpt_cnt;
    logic             first;
    logic             nege_r;
    logic             pose_r;
    logic             rpt_r;
    logic             move_r;
    logic             level_r;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        state   <= IDLE;
        db_cnt  <= '0;
        rpt_cnt <= '0;
        first   <= 1'b1;
        nege_r  <= 1'b0;
        pose_r  <= 1'b0;
        rpt_r   <= 1'b0;
        move_r  <= 1'b0;
        level_r <= 1'b1;
      end else begin
        sync1  <= key_in[i];
        sync2  <= sync1;
        // Flags are pulses: cleared every cycle unless an event fires below.
        nege_r <= 1'b0;
        pose_r <= 1'b0;
        rpt_r  <= 1'b0;
        move_r <= 1'b0;

        case (state)
          IDLE: begin
            level_r <= 1'b1;
            if (!sync2) begin
              state  <= FILTER_DN;
              db_cnt <= '0;
            end
          end

          FILTER_DN: begin
            if (sync2) begin
              // Bounce: the low level did not last long enough.
              state  <= IDLE;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state   <= DOWN;
              db_cnt  <= '0;
              nege_r  <= 1'b1;
              move_r  <= 1'b1;
              level_r <= 1'b0;
              rpt_cnt <= '0;
              first   <= 1'b1;
            end else begin
              db_cnt <= db_cnt + CNT_ONE;
            end
          end

          DOWN: begin
            if (sync2) begin
              // Candidate release; rpt_cnt is frozen so a glitch that
              // returns to DOWN resumes the repeat cadence where it was.
              state  <= FILTER_UP;
              db_cnt <= '0;
            end else if (!rpt_en[i]) begin
              rpt_cnt <= '0;
              first   <= 1'b1;
            end else if (rpt_cnt == (first ? DELAY_LAST : PERIOD_LAST)) begin
              rpt_r   <= 1'b1;
              move_r  <= 1'b1;
              rpt_cnt <= '0;
              first   <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + CNT_ONE;
            end
          end

          FILTER_UP: begin
            if (!sync2) begin
              // Release glitch: back to held without any flag.
              state  <= DOWN;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state   <= IDLE;
              db_cnt  <= '0;
              pose_r  <= 1'b1;
              level_r <= 1'b1;
              rpt_cnt <= '0;
              first   <= 1'b1;
            end else begin
              db_cnt <= db_cnt + CNT_ONE;
            end
          end

          default: begin
            state  <= IDLE;
            db_cnt <= '0;
          end
        endcase
      end
    end

    assign nege_flag[i] = nege_r;
    assign pose_flag[i] = pose_r;
    assign rpt_flag[i]  = rpt_r;
    assign move_flag[i] = move_r;
    assign key_state[i] = level_r;
  end

endmodule

// File: tb/tb_key_repeat_filter.sv
// tb/tb_key_repeat_filter.sv - directed self-checking bench for key_repeat_filter
module tb_key_repeat_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] rpt_en;
  logic [3:0] nege_flag;
  logic [3:0] pose_flag;
  logic [3:0] rpt_flag;
  logic [3:0] move_flag;
  logic [3:0] key_state;

  int checks = 0;
  int errors = 0;

  key_repeat_filter #(
    .N_KEYS       (4),
    .CNT_DEBOUNCE (8),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(5),
    .CNT_W        (25)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .rpt_en   (rpt_en),
    .nege_flag(nege_flag),
    .pose_flag(pose_flag),
    .rpt_flag (rpt_flag),
    .move_flag(move_flag),
    .key_state(key_state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are sampled and inputs
  // driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic       e_rpt;
    logic [3:0] e_vec;
    logic [3:0] e_rv;

    // Reset
    rst_n  = 1'b0;
    key_in = 4'hF;
    rpt_en = 4'b1001;
    tick();
    tick();
    chk("rst_nege", nege_flag, 4'h0);
    chk("rst_pose", pose_flag, 4'h0);
    chk("rst_rpt", rpt_flag, 4'h0);
    chk("rst_move", move_flag, 4'h0);
    chk("rst_state", key_state, 4'hF);
    rst_n = 1'b1;

    // Key 0: clean press held 60 cycles, then a 4-cycle release glitch,
    // more holding, then a clean release.
    key_in[0] = 1'b0;
    for (int k = 1; k <= 95; k++) begin
      tick();
      e_rpt = ((k >= 31) && (k <= 61) && ((k - 31) % 5 == 0)) || (k == 71) || (k == 76);
      chk("s1_nege0", {3'b000, nege_flag[0]}, {3'b000, (k == 11)});
      chk("s1_rpt0", {3'b000, rpt_flag[0]}, {3'b000, e_rpt});
      chk("s1_move0", {3'b000, move_flag[0]}, {3'b000, (k == 11) || e_rpt});
      chk("s1_pose0", {3'b000, pose_flag[0]}, {3'b000, (k == 85)});
      chk("s1_state0", {3'b000, key_state[0]}, {3'b000, (k < 11) || (k >= 85)});
      if (k == 60) key_in[0] = 1'b1;
      if (k == 64) key_in[0] = 1'b0;
      if (k == 74) key_in[0] = 1'b1;
    end

    // Key 1: low 5, high 3, then low and held.
    key_in[1] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("s2_nege1", {3'b000, nege_flag[1]}, {3'b000, (k == 19)});
      chk("s2_pose1", {3'b000, pose_flag[1]}, 4'h0);
      chk("s2_state1", {3'b000, key_state[1]}, {3'b000, (k < 19)});
      if (k == 5) key_in[1] = 1'b1;
      if (k == 8) key_in[1] = 1'b0;
    end

    // Key 2: repeat disabled, held 100 cycles.
    key_in[2] = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("s4_nege2", {3'b000, nege_flag[2]}, {3'b000, (k == 11)});
      chk("s4_rpt2", {3'b000, rpt_flag[2]}, 4'h0);
    end

    // Keys 0 and 3 pressed together (keys 1 and 2 still held).
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      tick();
      e_vec = (k == 11) ? 4'b1001 : 4'b0000;
      e_rv  = ((k == 31) || (k == 36)) ? 4'b1001 : 4'b0000;
      chk("s5_nege", nege_flag, e_vec);
      chk("s5_rpt", rpt_flag, e_rv);
      chk("s5_move", move_flag, e_vec | e_rv);
      chk("s5_pose", pose_flag, 4'h0);
      chk("s5_state", key_state, (k >= 11) ? 4'h0 : 4'b1001);
    end

    // One-cycle reset with all keys held, key 0 mid-repeat.
    rst_n = 1'b0;
    tick();
    chk("s6_rst_nege", nege_flag, 4'h0);
    chk("s6_rst_rpt", rpt_flag, 4'h0);
    chk("s6_rst_move", move_flag, 4'h0);
    chk("s6_rst_pose", pose_flag, 4'h0);
    chk("s6_rst_state", key_state, 4'hF);
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("s6_nege", nege_flag, (k == 11) ? 4'hF : 4'h0);
      chk("s6_rpt", rpt_flag, 4'h0);
      chk("s6_state", key_state, (k >= 11) ? 4'h0 : 4'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
